// File: rtl/deadlock_pkg.sv
// Shared definitions for the deadlock supervisor: controller states and the
// default monitor count / hold time used by the top level and monitor wrappers.
package deadlock_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_N_MON       = 4;
    localparam int DEF_HOLD_CYCLES = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        SCAN     = 3'd2,
        REPORT   = 3'd3,
        HALT     = 3'd4
    } state_t;

endpackage

// File: rtl/deadlock_debounce.sv
// Counts consecutive armed-and-blocked cycles and flags the cycle on which
// the run reaches HOLD_CYCLES. Any break in the run clears the count.
module deadlock_debounce #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic i_armed,
    input  logic i_hit,
    output logic o_confirm
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_counting;

    // One spare bit so the compare stays exact when HOLD_CYCLES fills CNT_W.
    assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
    assign w_counting = i_armed & i_hit;
    assign o_confirm  = w_counting & (w_cnt_inc == (CNT_W+1)'(HOLD_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_counting && !o_confirm) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock supervisor: confirms persistent blocking, snapshots the blocked
// monitors and serialises their indices over valid/ready, then halts.
module deadlock_report_ctrl
    import deadlock_pkg::*;
#(
    parameter int N_MON       = DEF_N_MON,
    parameter int IDX_W       = 2,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_MON-1:0] mon_block,
    output logic             report_valid,
    output logic [IDX_W-1:0] report_idx,
    input  logic             report_ready,
    output logic             deadlock_found,
    output logic             report_done
);

    state_t           r_state;
    logic [N_MON-1:0] r_snap;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_found;
    logic             r_done;

    logic             w_hit;
    logic             w_armed;
    logic             w_confirm;
    logic             w_handshake;
    logic [N_MON-1:0] w_idx_mask;
    logic [N_MON-1:0] w_snap_left;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] w_idx_next;

    assign w_hit       = enable & (|mon_block);
    assign w_armed     = (r_state == IDLE) || (r_state == DEBOUNCE);
    assign w_handshake = r_valid & report_ready;

    deadlock_debounce #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .i_armed   (w_armed),
        .i_hit     (w_hit),
        .o_confirm (w_confirm)
    );

    // One-hot of the index currently on offer, used to retire it from snap.
    genvar gi;
    generate
        for (gi = 0; gi < N_MON; gi++) begin : g_idx_mask
            assign w_idx_mask[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

    assign w_snap_left = r_snap & ~w_idx_mask;
    assign w_ptr_next  = (r_ptr == IDX_W'(N_MON-1)) ? '0 : r_ptr + 1'b1;
    assign w_idx_next  = (r_idx == IDX_W'(N_MON-1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_found <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DEBOUNCE: begin
                    // The debouncer only confirms while blocked, so snap is nonzero.
                    if (w_confirm) begin
                        r_snap  <= mon_block;
                        r_found <= 1'b1;
                        r_ptr   <= '0;
                        r_state <= SCAN;
                    end else if (w_hit) begin
                        r_state <= DEBOUNCE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    if (r_snap[r_ptr]) begin
                        r_idx   <= r_ptr;
                        r_valid <= 1'b1;
                        r_state <= REPORT;
                    end else begin
                        r_ptr <= w_ptr_next;
                    end
                end
                REPORT: begin
                    if (w_handshake) begin
                        r_snap  <= w_snap_left;
                        r_valid <= 1'b0;
                        r_ptr   <= w_idx_next;
                        if (|w_snap_left) begin
                            r_state <= SCAN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= HALT;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign report_valid   = r_valid;
    assign report_idx     = r_idx;
    assign deadlock_found = r_found;
    assign report_done    = r_done;

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Bench for deadlock_report_ctrl: a default build and a HOLD_CYCLES=1 build,
// each checked every cycle against a run-length / snapshot model.
module tb_deadlock_report_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build (HOLD_CYCLES=16)
    logic       rst0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0;
    logic [3:0] mb0  = 4'b0;
    logic       v0, f0, d0;
    logic [1:0] i0;

    // HOLD_CYCLES=1 build
    logic       rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0;
    logic [3:0] mb1  = 4'b0;
    logic       v1, f1, d1;
    logic [1:0] i1;

    deadlock_report_ctrl dut0 (
        .clock(clk), .reset(rst0), .enable(en0), .mon_block(mb0),
        .report_valid(v0), .report_idx(i0), .report_ready(rdy0),
        .deadlock_found(f0), .report_done(d0)
    );

    deadlock_report_ctrl #(.N_MON(4), .IDX_W(2), .HOLD_CYCLES(1), .CNT_W(1)) dut1 (
        .clock(clk), .reset(rst1), .enable(en1), .mon_block(mb1),
        .report_valid(v1), .report_idx(i1), .report_ready(rdy1),
        .deadlock_found(f1), .report_done(d1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: blocked-run length, sticky flag, remaining snapshot bits and a
    // countdown until the next index is offered.
    int         m_run[2];
    int         m_wait[2];
    logic       m_init[2];
    logic       m_found[2];
    logic       m_valid[2];
    logic       m_done[2];
    logic [1:0] m_idx[2];
    logic [3:0] m_snap[2];

    int done_cnt[2];
    int log_code[2];
    logic v_seen0;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input int k, input int hold, input logic r, input logic e,
                              input logic [3:0] b, input logic y);
        int nx;
        if (r) begin
            m_init[k] = 1'b1; m_run[k] = 0; m_wait[k] = 0; m_found[k] = 1'b0;
            m_valid[k] = 1'b0; m_done[k] = 1'b0; m_idx[k] = 2'd0; m_snap[k] = 4'd0;
        end else begin
            m_done[k] = 1'b0;
            if (!m_found[k]) begin
                if (e && b != 4'd0) begin
                    m_run[k]++;
                    if (m_run[k] >= hold) begin
                        m_found[k] = 1'b1;
                        m_snap[k]  = b;
                        m_wait[k]  = lowest(b) + 1;
                        m_run[k]   = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end else if (m_valid[k]) begin
                if (y) begin
                    m_valid[k] = 1'b0;
                    nx = lowest(m_snap[k]);
                    if (nx < 0) m_done[k] = 1'b1;
                    else        m_wait[k] = nx - int'(m_idx[k]);
                end
            end else if (m_snap[k] != 4'd0) begin
                m_wait[k]--;
                if (m_wait[k] == 0) begin
                    nx = lowest(m_snap[k]);
                    m_valid[k]     = 1'b1;
                    m_idx[k]       = nx[1:0];
                    m_snap[k][nx]  = 1'b0;
                end
            end
        end
    endtask

    // Compare process: advance the model at each edge, check the DUTs 1 time unit later.
    initial begin
        logic       p_v0, p_v1;
        logic [1:0] p_i0, p_i1;
        p_v0 = 1'b0; p_v1 = 1'b0; p_i0 = 2'd0; p_i1 = 2'd0;
        done_cnt[0] = 0; done_cnt[1] = 0; log_code[0] = 0; log_code[1] = 0;
        v_seen0 = 1'b0; m_init[0] = 1'b0; m_init[1] = 1'b0;
        forever begin
            @(posedge clk);
            if (rst0) begin log_code[0] = 0; v_seen0 = 1'b0; end
            else if (p_v0 && rdy0) log_code[0] = log_code[0] * 10 + int'(p_i0) + 1;
            if (rst1) log_code[1] = 0;
            else if (p_v1 && rdy1) log_code[1] = log_code[1] * 10 + int'(p_i1) + 1;
            model_step(0, 16, rst0, en0, mb0, rdy0);
            model_step(1, 1,  rst1, en1, mb1, rdy1);
            #1;
            if (m_init[0]) begin
                check("dut0 report_valid", 32'(v0), 32'(m_valid[0]));
                check("dut0 report_idx", 32'(i0), 32'(m_idx[0]));
                check("dut0 deadlock_found", 32'(f0), 32'(m_found[0]));
                check("dut0 report_done", 32'(d0), 32'(m_done[0]));
            end
            if (m_init[1]) begin
                check("dut1 report_valid", 32'(v1), 32'(m_valid[1]));
                check("dut1 report_idx", 32'(i1), 32'(m_idx[1]));
                check("dut1 deadlock_found", 32'(f1), 32'(m_found[1]));
                check("dut1 report_done", 32'(d1), 32'(m_done[1]));
            end
            if (d0 === 1'b1) done_cnt[0]++;
            if (d1 === 1'b1) done_cnt[1]++;
            if (v0 === 1'b1) v_seen0 = 1'b1;
            p_v0 = v0; p_i0 = i0; p_v1 = v1; p_i1 = i1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int k, input int limit, input string name);
        int start;
        int t;
        start = done_cnt[k];
        t = 0;
        while (done_cnt[k] == start && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(done_cnt[k] - start), 32'd1);
    endtask

    task automatic reset0();
        rst0 = 1'b1; en0 = 1'b0; mb0 = 4'b0; rdy0 = 1'b0;
        cyc(2);
        rst0 = 1'b0;
    endtask

    initial begin
        int t;
        int stall;
        cyc(2);
        check("reset valid", 32'(v0), 32'd0);
        check("reset idx", 32'(i0), 32'd0);
        check("reset found", 32'(f0), 32'd0);
        check("reset done", 32'(d0), 32'd0);
        rst0 = 1'b0;

        // No deadlock: 15 blocked cycles then release
        en0 = 1'b1; mb0 = 4'b0010;
        cyc(15);
        mb0 = 4'b0;
        cyc(3);
        check("short run found", 32'(f0), 32'd0);
        check("short run no valid", 32'(v_seen0), 32'd0);

        // Confirmed single blocked monitor
        mb0 = 4'b0100; rdy0 = 1'b1;
        cyc(15);
        check("single found@15", 32'(f0), 32'd0);
        cyc(1);
        check("single found@16", 32'(f0), 32'd1);
        mb0 = 4'b0;
        wait_done(0, 20, "single done");
        check("single log", 32'(log_code[0]), 32'd3);
        cyc(3);
        check("halt sticky", 32'(f0), 32'd1);

        // Multiple monitors with backpressure
        reset0();
        en0 = 1'b1; mb0 = 4'b1011;
        cyc(16);
        check("multi found", 32'(f0), 32'd1);
        mb0 = 4'b0;
        stall = 0; t = 0;
        while (done_cnt[0] == 0 + done_cnt[0] && log_code[0] != 124 && t < 80) begin
            @(negedge clk);
            t++;
            if (v0) begin
                stall++;
                rdy0 = (stall > 3);
            end else begin
                stall = 0;
                rdy0 = t[0];
            end
        end
        rdy0 = 1'b0;
        cyc(2);
        check("multi log", 32'(log_code[0]), 32'd124);
        check("multi halted", 32'(v0), 32'd0);

        // Glitch restarts the count; blocked identity changes during debounce
        reset0();
        en0 = 1'b1; mb0 = 4'b0001;
        cyc(10);
        mb0 = 4'b0;
        cyc(1);
        for (int i = 0; i < 15; i++) begin
            mb0 = i[0] ? 4'b1000 : 4'b0110;
            cyc(1);
        end
        check("glitch found@15", 32'(f0), 32'd0);
        mb0 = 4'b1000;
        cyc(1);
        check("glitch found@16", 32'(f0), 32'd1);
        mb0 = 4'b0; rdy0 = 1'b1;
        wait_done(0, 20, "glitch done");
        check("glitch log", 32'(log_code[0]), 32'd4);

        // Enable drop at cycle 8 clears the count
        reset0();
        en0 = 1'b1; mb0 = 4'b1111;
        cyc(7);
        en0 = 1'b0;
        cyc(1);
        en0 = 1'b1;
        cyc(15);
        check("enable found@15", 32'(f0), 32'd0);
        cyc(1);
        check("enable found@16", 32'(f0), 32'd1);
        mb0 = 4'b0; rdy0 = 1'b1;
        wait_done(0, 30, "enable done");
        check("enable log", 32'(log_code[0]), 32'd1234);

        // Reset in the middle of a handshake
        reset0();
        en0 = 1'b1; mb0 = 4'b0110;
        cyc(16);
        mb0 = 4'b0;
        t = 0;
        while (!v0 && t < 10) begin cyc(1); t++; end
        check("midop valid", 32'(v0), 32'd1);
        check("midop idx", 32'(i0), 32'd1);
        rst0 = 1'b1;
        cyc(1);
        check("midop rst valid", 32'(v0), 32'd0);
        check("midop rst idx", 32'(i0), 32'd0);
        check("midop rst found", 32'(f0), 32'd0);
        check("midop rst done", 32'(d0), 32'd0);
        rst0 = 1'b0;
        cyc(2);
        mb0 = 4'b0001; rdy0 = 1'b1;
        cyc(16);
        mb0 = 4'b0;
        wait_done(0, 20, "fresh done");
        check("fresh log", 32'(log_code[0]), 32'd1);

        // HOLD_CYCLES=1 build
        rst1 = 1'b0;
        cyc(1);
        en1 = 1'b1; mb1 = 4'b1000;
        cyc(1);
        mb1 = 4'b0;
        check("hold1 found", 32'(f1), 32'd1);
        t = 0;
        while (!v1 && t < 8) begin cyc(1); t++; end
        check("hold1 latency", 32'(t), 32'd4);
        check("hold1 idx", 32'(i1), 32'd3);
        rdy1 = 1'b1;
        wait_done(1, 10, "hold1 done");
        check("hold1 log", 32'(log_code[1]), 32'd4);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
